// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit feeding decode through a small FIFO.
// The fetch PC issues one word request per accepted handshake. The response
// comes back one cycle later and is queued together with its PC.
// Optional feature: define FETCH_QUEUE_BYPASS_EN to present a response that
// arrives while the FIFO is empty to decode in the same cycle.
//
// Handshakes: a transfer happens on a rising edge where the producer side
// (IMEM_REQ toward memory, DE_VALID toward decode) and the consumer side
// (IMEM_READY, DE_READY) are both high. IMEM_REQ and DE_VALID never depend
// on the matching ready input.
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       CLK,
    input  logic                       RST,
    output logic                       IMEM_REQ,
    output logic [31:0]                IMEM_ADDR,
    input  logic                       IMEM_READY,
    input  logic [31:0]                IMEM_RDATA,
    output logic                       DE_VALID,
    input  logic                       DE_READY,
    output logic [31:0]                DE_IR,
    output logic [31:0]                DE_PC,
    output logic [31:0]                DE_NEXT_PC,
    input  logic                       REDIRECT,
    input  logic [31:0]                REDIRECT_PC,
    output logic [$clog2(DEPTH+1)-1:0] COUNT
);

    localparam int          AW  = $clog2(DEPTH);
    localparam int          CW  = $clog2(DEPTH + 1);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   fetch_pc;
    logic          inflight;
    logic [31:0]   inflight_pc;
    logic [31:0]   ir_mem [DEPTH];
    logic [31:0]   pc_mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [31:0]   last_pc;
    logic [31:0]   last_next_pc;

    logic [CW:0]   occupancy;
    logic          accept;
    logic          fifo_valid;
    logic          de_valid;
    logic [31:0]   sel_ir;
    logic [31:0]   sel_pc;
    logic          push;
    logic          pop;

    // Request gating, head selection and push/pop decisions.
    always_comb begin
        occupancy  = {1'b0, count} + {{CW{1'b0}}, inflight};
        // Reset gates the request so nothing is issued while RST is low.
        IMEM_REQ   = RST && !REDIRECT && (occupancy < (CW + 1)'(DEPTH));
        IMEM_ADDR  = fetch_pc;
        accept     = IMEM_REQ && IMEM_READY;
        fifo_valid = (count != '0);
        // A redirect flushes everything, so it blocks both ends of the FIFO.
        pop        = fifo_valid && DE_READY && !REDIRECT;
`ifdef FETCH_QUEUE_BYPASS_EN
        de_valid   = fifo_valid || (inflight && !REDIRECT);
        sel_ir     = fifo_valid ? ir_mem[rd_ptr] : IMEM_RDATA;
        sel_pc     = fifo_valid ? pc_mem[rd_ptr] : inflight_pc;
        // A bypassed response consumed by decode is never queued.
        push       = inflight && !REDIRECT && !(!fifo_valid && DE_READY);
`else
        de_valid   = fifo_valid;
        sel_ir     = ir_mem[rd_ptr];
        sel_pc     = pc_mem[rd_ptr];
        push       = inflight && !REDIRECT;
`endif
        DE_VALID   = de_valid;
        DE_IR      = de_valid ? sel_ir : NOP;
        DE_PC      = de_valid ? sel_pc : last_pc;
        DE_NEXT_PC = de_valid ? sel_pc + 32'd4 : last_next_pc;
        COUNT      = count;
    end

    // Fetch PC, in-flight tracking, FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'd0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (REDIRECT) begin
            fetch_pc    <= REDIRECT_PC & ~32'd3;
            inflight    <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end
            inflight    <= accept;
            inflight_pc <= fetch_pc;
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage: response word and the PC it was fetched from.
    always_ff @(posedge CLK) begin
        if (push) begin
            ir_mem[wr_ptr] <= IMEM_RDATA;
            pc_mem[wr_ptr] <= inflight_pc;
        end
    end

    // Remember the last PC shown to decode so it holds while DE_VALID is low.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            last_pc      <= 32'd0;
            last_next_pc <= 32'd0;
        end else if (de_valid) begin
            last_pc      <= sel_pc;
            last_next_pc <= sel_pc + 32'd4;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed phases followed by random traffic, each cycle
// compared against a queue-based model of the fetch queue.
module tb_fetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] K        = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic                       CLK;
    logic                       RST;
    logic                       IMEM_REQ;
    logic [31:0]                IMEM_ADDR;
    logic                       IMEM_READY;
    logic [31:0]                IMEM_RDATA;
    logic                       DE_VALID;
    logic                       DE_READY;
    logic [31:0]                DE_IR;
    logic [31:0]                DE_PC;
    logic [31:0]                DE_NEXT_PC;
    logic                       REDIRECT;
    logic [31:0]                REDIRECT_PC;
    logic [$clog2(DEPTH+1)-1:0] COUNT;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .IMEM_REQ   (IMEM_REQ),
        .IMEM_ADDR  (IMEM_ADDR),
        .IMEM_READY (IMEM_READY),
        .IMEM_RDATA (IMEM_RDATA),
        .DE_VALID   (DE_VALID),
        .DE_READY   (DE_READY),
        .DE_IR      (DE_IR),
        .DE_PC      (DE_PC),
        .DE_NEXT_PC (DE_NEXT_PC),
        .REDIRECT   (REDIRECT),
        .REDIRECT_PC(REDIRECT_PC),
        .COUNT      (COUNT)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Scoreboard: PCs expected at decode, in order; data is PC ^ K.
    logic [31:0] exp_q[$];
    logic        m_infl;
    logic [31:0] m_infl_pc;
    logic [31:0] m_pc;
    logic [31:0] m_last_pc;
    logic [31:0] m_last_next;

    // Memory model: answers the request accepted on the previous edge.
    logic        mem_pending;
    logic [31:0] mem_addr;

    int vectors;
    int miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_infl      = 1'b0;
        m_infl_pc   = 32'd0;
        m_pc        = RESET_PC;
        m_last_pc   = 32'd0;
        m_last_next = 32'd0;
        mem_pending = 1'b0;
        mem_addr    = 32'd0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_imem_req"}, 32'(IMEM_REQ), 32'd0);
        chk({tag, "_imem_addr"}, IMEM_ADDR, RESET_PC);
        chk({tag, "_de_valid"}, 32'(DE_VALID), 32'd0);
        chk({tag, "_de_ir"}, DE_IR, NOP);
        chk({tag, "_de_pc"}, DE_PC, 32'd0);
        chk({tag, "_de_next_pc"}, DE_NEXT_PC, 32'd0);
        chk({tag, "_count"}, 32'(COUNT), 32'd0);
    endtask

    // Driver + checker for one cycle. Entered just after a falling edge,
    // leaves just after the next falling edge.
    task automatic step(input bit rdy, input bit dr, input bit redir, input logic [31:0] rpc);
        logic        exp_req;
        logic        exp_valid;
        logic        byp;
        logic [31:0] head_pc;
        logic        req_seen;
        logic [31:0] addr_seen;
        IMEM_READY  = rdy;
        DE_READY    = dr;
        REDIRECT    = redir;
        REDIRECT_PC = rpc;
        IMEM_RDATA  = mem_pending ? (mem_addr ^ K) : $urandom;
        #1;
        exp_req = ((exp_q.size() + int'(m_infl)) < DEPTH) && !redir;
        byp     = 1'b0;
`ifdef FETCH_QUEUE_BYPASS_EN
        byp     = m_infl && (exp_q.size() == 0) && !redir;
`endif
        exp_valid = (exp_q.size() > 0) || byp;
        head_pc   = (exp_q.size() > 0) ? exp_q[0] : m_infl_pc;
        chk("imem_req", 32'(IMEM_REQ), 32'(exp_req));
        chk("imem_addr", IMEM_ADDR, m_pc);
        chk("count", 32'(COUNT), 32'(exp_q.size()));
        chk("de_valid", 32'(DE_VALID), 32'(exp_valid));
        chk("de_ir", DE_IR, exp_valid ? (head_pc ^ K) : NOP);
        chk("de_pc", DE_PC, exp_valid ? head_pc : m_last_pc);
        chk("de_next_pc", DE_NEXT_PC, exp_valid ? head_pc + 32'd4 : m_last_next);
        // Advance the model across the coming edge.
        if (exp_valid) begin
            m_last_pc   = head_pc;
            m_last_next = head_pc + 32'd4;
        end
        if (redir) begin
            exp_q.delete();
            m_infl = 1'b0;
            m_pc   = rpc & ~32'd3;
        end else begin
            if ((exp_q.size() > 0) && dr) void'(exp_q.pop_front());
            if (m_infl && !(byp && dr)) exp_q.push_back(m_infl_pc);
            m_infl    = exp_req && rdy;
            m_infl_pc = m_pc;
            if (exp_req && rdy) m_pc = m_pc + 32'd4;
        end
        req_seen  = IMEM_REQ;
        addr_seen = IMEM_ADDR;
        @(posedge CLK);
        mem_pending = req_seen && rdy;
        mem_addr    = addr_seen;
        @(negedge CLK);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        RST         = 1'b0;
        IMEM_READY  = 1'b0;
        IMEM_RDATA  = 32'd0;
        DE_READY    = 1'b0;
        REDIRECT    = 1'b0;
        REDIRECT_PC = 32'd0;
        model_reset();

        // Reset values, then release at a falling edge.
        @(negedge CLK);
        chk_reset_outputs("reset");
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;

        // Streaming: one PC per cycle after the initial latency.
        for (int i = 0; i < 10; i++) step(1, 1, 0, 32'd0);

        // Backpressure: fill to DEPTH, then drain in order.
        for (int i = 0; i < 8; i++) step(1, 0, 0, 32'd0);
        chk("full_count", 32'(COUNT), DEPTH);
        chk("full_no_req", 32'(IMEM_REQ), 32'd0);
        for (int i = 0; i < 8; i++) step(0, 1, 0, 32'd0);

        // Redirect with three entries queued and one response in flight.
        for (int k = 0; k < 20 && !(exp_q.size() == 3 && m_infl); k++) step(1, 0, 0, 32'd0);
        chk("pre_redirect_count", 32'(COUNT), 32'd3);
        step(1, 0, 1, 32'h0000_0103);
        chk("post_redirect_count", 32'(COUNT), 32'd0);
        chk("post_redirect_addr", IMEM_ADDR, 32'h0000_0100);
        for (int i = 0; i < 6; i++) step(1, 1, 0, 32'd0);

        // Alternating memory readiness.
        for (int i = 0; i < 16; i++) step(i[0] == 1'b0, 1, 0, 32'd0);

        // PC wrap across 2^32.
        step(1, 1, 1, 32'hFFFF_FFF8);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 32'd0);

        // Asynchronous reset mid-stream with two entries queued.
        for (int k = 0; k < 20 && exp_q.size() != 2; k++) step(1, 0, 0, 32'd0);
        chk("pre_reset_count", 32'(COUNT), 32'd2);
        IMEM_READY = 1'b0;
        DE_READY   = 1'b1;
        #2;
        RST = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        for (int i = 0; i < 6; i++) step(1, 1, 0, 32'd0);

        // Random traffic with occasional redirects.
        for (int i = 0; i < 300; i++) begin
            step($urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 15) == 0, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, giving the first fetch address after reset.
REQ-003 The block SHALL have port CLK  input  1  the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port IMEM_REQ  output  1  instruction read request.
REQ-006 The block SHALL have port IMEM_ADDR  output  32  word-aligned fetch address.
REQ-007 The block SHALL have port IMEM_READY  input  1  memory accepts the request this cycle.
REQ-008 The block SHALL have port IMEM_RDATA  input  32  instruction, valid the cycle after acceptance.
REQ-009 The block SHALL have port DE_VALID  output  1  head entry available to decode.
REQ-010 The block SHALL have port DE_READY  input  1  decode consumes the head this cycle (driven as not-stall).
REQ-011 The block SHALL have ports DE_IR, DE_PC, DE_NEXT_PC  output  32 each  head instruction, its PC, and PC+4.
REQ-012 The block SHALL have ports REDIRECT  input  1 and REDIRECT_PC  input  32  flush and new fetch target.
REQ-013 The block SHALL have port COUNT  output  clog2(DEPTH+1)  occupied entries.

Function
REQ-014 A request SHALL be accepted on a rising edge when IMEM_REQ and IMEM_READY are both high.
REQ-015 IMEM_REQ SHALL be high only when COUNT plus in-flight responses (0 or 1) is less than DEPTH and REDIRECT is low.
REQ-016 The fetch PC SHALL advance by 4 on each accepted request and wrap modulo 2^32.
REQ-017 The response to a request accepted at edge N SHALL be written, together with its PC, into the FIFO at edge N+1.
REQ-018 DE_VALID SHALL be high exactly when COUNT is greater than 0; the head SHALL pop when DE_VALID and DE_READY are both high.
REQ-019 A simultaneous push and pop SHALL leave COUNT unchanged, including when COUNT equals DEPTH-1 or DEPTH.
REQ-020 When DE_VALID is low, DE_IR SHALL be 32'h0000_0013 (NOP), and DE_PC and DE_NEXT_PC SHALL hold their last values.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH; COUNT SHALL never exceed DEPTH and a pop SHALL never occur when empty.
REQ-022 REDIRECT high at edge N SHALL empty the FIFO and set the fetch PC to {REDIRECT_PC[31:2],2'b00}.
REQ-023 On REDIRECT, any in-flight response returning at edge N+1 SHALL be discarded.
REQ-024 REDIRECT SHALL take priority over push, pop and request.
REQ-025 IMEM_ADDR after a REDIRECT SHALL equal the new PC, with IMEM_REQ high in cycle N+1.
REQ-026 Request-to-DE_VALID latency SHALL be 2 cycles when the FIFO is empty and the bypass is not compiled in.

Reset
REQ-027 While RST is low: IMEM_REQ=0, fetch PC=RESET_PC, FIFO empty, COUNT=0, DE_VALID=0, DE_IR=32'h0000_0013, DE_PC=0, DE_NEXT_PC=0, and any in-flight response is discarded.
REQ-028 IMEM_REQ SHALL assert, with IMEM_ADDR=RESET_PC, in the first cycle after RST deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all entries and in-flight responses with no pop delivered.

Configuration
REQ-030 With macro FETCH_QUEUE_BYPASS_EN defined, a non-discarded response arriving while COUNT=0 SHALL drive DE_VALID, DE_IR, DE_PC and DE_NEXT_PC combinationally in that same cycle.
REQ-031 Under FETCH_QUEUE_BYPASS_EN, if DE_READY is high the bypassed entry SHALL not be written to the FIFO; otherwise it SHALL be written normally. Latency becomes 1 cycle.
REQ-032 Without FETCH_QUEUE_BYPASS_EN, all responses SHALL pass through the FIFO per REQ-026.

Verification
REQ-033 Release reset, hold IMEM_READY=1 and DE_READY=1 with memory returning addr^32'hA5A5_0000 -> DE_PC sequence 0,4,8,... one per cycle, first DE_VALID at cycle 2 (cycle 1 with the bypass).
REQ-034 Hold DE_READY=0 with DEPTH=4 -> COUNT reaches 4, IMEM_REQ=0 from then on, with no overflow; release DE_READY -> entries drain in order PC 0,4,8,12.
REQ-035 Assert REDIRECT with REDIRECT_PC=32'h0000_0103 while COUNT=3 and a response is in flight -> COUNT=0 next cycle, stale data never appears on DE, next IMEM_ADDR=32'h0000_0100.
REQ-036 Toggle IMEM_READY 1010... -> no duplicate or skipped PC, and DE_PC stays strictly +4 monotonic.
REQ-037 Start with fetch PC=32'hFFFF_FFF8 via REDIRECT -> DE_PC sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-038 Assert RST low mid-stream with COUNT=2 -> all outputs take their REQ-027 values asynchronously, and refetch starts at RESET_PC.
